serial_tx_arbiter: RTL

Shares the processor's single 8-bit serial output port among several requesters (CPU store path, debug/trace unit, boot monitor). Each requester pushes bytes into its own small FIFO. The arbiter grants one requester at a time and holds the grant until that requester's message-terminating byte, so strings never interleave. Output drives the `serial_out` / `serial_wren_out` pair, throttled by `serial_ready_in`.

---
 rtl/serial_arb_pkg.sv | 15 +
 rtl/sync_fifo.sv | 34 +++
 rtl/serial_tx_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_arb_pkg.sv
// serial_arb_pkg: shared state type, widths and round-robin pick for serial_tx_arbiter
package serial_arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int BYTE_W = 8;
   localparam int ENTRY_W = BYTE_W + 1;
   // Scans 4 slots ascending from rr_ptr with wrap; slots beyond NUM_REQ must be zero.
   function automatic logic [3:0] rr_pick(input logic [3:0] nonempty, input logic [1:0] rr_ptr);
      logic [1:0] idx;
      rr_pick = '0;
      for (int i = 3; i >= 0; i--) begin
         idx = rr_ptr + 2'(i);
         if (nonempty[idx]) rr_pick = 4'b1 << idx;
      end
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: register-array FIFO with wrap-bit pointers; head is readable as dout whenever not empty
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic clock,
   input  logic reset,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic full,
   output logic empty,
   output logic [AW:0] count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   assign count = wr_ptr - rd_ptr;
   assign empty = wr_ptr == rd_ptr;
   assign full = count == (AW+1)'(DEPTH);
   assign dout = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clock)
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin, message-atomic sharing of one serial byte port among NUM_REQ FIFOs
module serial_tx_arbiter
   import serial_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT = 64
) (
   input  logic clock,
   input  logic reset,
   input  logic [NUM_REQ*BYTE_W-1:0] req_data,
   input  logic [NUM_REQ-1:0] req_last,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic serial_ready_in,
   output logic [BYTE_W-1:0] serial_out,
   output logic serial_wren_out,
   output logic [NUM_REQ-1:0] grant_out,
   output logic busy_out
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   state_t state;
   logic [IW-1:0] owner, rr_ptr, pick_idx, next_ptr;
   logic [CW-1:0] idle_cnt;
   logic [NUM_REQ-1:0] full, empty, nonempty, push, pop;
   logic [ENTRY_W-1:0] dout [NUM_REQ];
   logic [AW:0] count [NUM_REQ];
   logic [3:0] pick;
   logic [ENTRY_W-1:0] head;
   logic head_valid, any_data;
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
      assign req_ready[i] = !reset && !full[i];
      assign push[i] = req_valid[i] && req_ready[i];
      assign pop[i] = state == GRANT && owner == IW'(i) && !empty[i] && serial_ready_in;
      sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
         .clock(clock),
         .reset(reset),
         .push(push[i]),
         .pop(pop[i]),
         .din({req_last[i], req_data[i*BYTE_W +: BYTE_W]}),
         .dout(dout[i]),
         .full(full[i]),
         .empty(empty[i]),
         .count(count[i])
      );
   end
   assign nonempty = ~empty;
   assign pick = rr_pick(4'(nonempty), 2'(rr_ptr));
   assign head = dout[owner];
   assign head_valid = !empty[owner];
   assign next_ptr = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
   assign busy_out = !reset && (state == GRANT || any_data);
   always_comb begin
      any_data = 1'b0;
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         any_data = any_data | (count[i] != '0);
         if (pick[i]) pick_idx = IW'(i);
      end
   end
   // Backpressure with data waiting never reaches the idle counter: only an empty owner FIFO counts.
   always_ff @(posedge clock) begin
      serial_wren_out <= 1'b0;
      if (reset) begin
         state <= IDLE;
         owner <= '0;
         rr_ptr <= '0;
         idle_cnt <= '0;
         serial_out <= '0;
         grant_out <= '0;
      end else if (state == IDLE) begin
         if (|pick) begin
            state <= GRANT;
            owner <= pick_idx;
            grant_out <= pick[NUM_REQ-1:0];
            idle_cnt <= '0;
         end
      end else if (head_valid) begin
         if (serial_ready_in) begin
            serial_out <= head[BYTE_W-1:0];
            serial_wren_out <= 1'b1;
            idle_cnt <= '0;
            if (head[BYTE_W]) begin
               state <= IDLE;
               rr_ptr <= next_ptr;
               grant_out <= '0;
            end
         end
      end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
         state <= IDLE;
         rr_ptr <= next_ptr;
         grant_out <= '0;
      end else
         idle_cnt <= idle_cnt + 1'b1;
   end
endmodule
